// File: rtl/lives_manager.sv
// Lives bookkeeping for the brick-breaker game: new game, play, respawn freeze and game over.
// Optional blink-modulated display output is enabled with LIVES_BLINK_EN.
//
//   state     | meaning
//   S_IDLE    | after reset, waiting for NewGame, Lives=0
//   S_PLAY    | ball in play, loss/bonus events accepted
//   S_RESPAWN | ball/paddle frozen for RESPAWN_CYCLES, bonus still accepted
//   S_OVER    | last life lost, waiting for NewGame
module lives_manager #(
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned MAX_LIVES      = 9,
  parameter int unsigned RESPAWN_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES   = 12_500_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       NewGame,
  input  logic       BallLost,
  input  logic       BonusLife,
  output logic [7:0] Lives,
  output logic       Respawn,
  output logic       GameOver
`ifdef LIVES_BLINK_EN
  ,
  output logic [7:0] LivesDisp
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_RESPAWN, S_OVER} state_t;

  localparam logic [7:0]  INIT_L    = 8'(INIT_LIVES);
  localparam logic [7:0]  MAX_L     = 8'(MAX_LIVES);
  localparam logic [31:0] RCNT_LOAD = 32'(RESPAWN_CYCLES - 1);

  generate
    if (INIT_LIVES < 1 || INIT_LIVES > MAX_LIVES || MAX_LIVES > 9 ||
        RESPAWN_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
      $error("lives_manager: parameter out of range");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [7:0]  lives_q, lives_d;
  logic        respawn_q, respawn_d;
  logic        game_over_q, game_over_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic [7:0]  lives_inc;

  assign lives_inc = (lives_q < MAX_L) ? lives_q + 8'd1 : MAX_L;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    respawn_d   = respawn_q;
    game_over_d = game_over_q;
    rcnt_d      = rcnt_q;
    if (NewGame) begin
      state_d     = S_PLAY;
      lives_d     = INIT_L;
      respawn_d   = 1'b0;
      game_over_d = 1'b0;
      rcnt_d      = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          // A simultaneous bonus cancels the loss but the ball is still gone.
          if (BallLost && (BonusLife || lives_q > 8'd1)) begin
            if (!BonusLife) lives_d = lives_q - 8'd1;
            state_d   = S_RESPAWN;
            respawn_d = 1'b1;
            rcnt_d    = RCNT_LOAD;
          end else if (BallLost) begin
            lives_d     = '0;
            state_d     = S_OVER;
            game_over_d = 1'b1;
          end else if (BonusLife) begin
            lives_d = lives_inc;
          end
        end
        S_RESPAWN: begin
          if (BonusLife) lives_d = lives_inc;
          if (rcnt_q == '0) begin
            state_d   = S_PLAY;
            respawn_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign Lives    = lives_q;
  assign Respawn  = respawn_q;
  assign GameOver = game_over_q;

`ifdef LIVES_BLINK_EN
  localparam logic [31:0] BLINK_LOAD = 32'(BLINK_CYCLES - 1);

  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  lives_disp_q, lives_disp_d;

  // Phase 0 blanks the display; every respawn starts blanked.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (state_d == S_RESPAWN) begin
      if (state_q != S_RESPAWN) begin
        blink_cnt_d = BLINK_LOAD;
      end else if (blink_cnt_q == '0) begin
        blink_cnt_d   = BLINK_LOAD;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q - 32'd1;
        blink_phase_d = blink_phase_q;
      end
    end
    lives_disp_d = (state_d == S_RESPAWN && !blink_phase_d) ? 8'd0 : lives_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      lives_disp_q  <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      lives_disp_q  <= lives_disp_d;
    end
  end

  assign LivesDisp = lives_disp_q;
`endif

endmodule

// File: tb/tb_lives_manager.sv
// Bench for lives_manager: directed vector table followed by random events against a reference model.
// Checks LivesDisp as well when built with LIVES_BLINK_EN.
module tb_lives_manager;

  localparam int INIT = 3;
  localparam int MAXL = 9;
  localparam int RC   = 4;
  localparam int BC   = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       NewGame = 1'b0;
  logic       BallLost = 1'b0;
  logic       BonusLife = 1'b0;
  logic [7:0] Lives;
  logic       Respawn;
  logic       GameOver;
`ifdef LIVES_BLINK_EN
  logic [7:0] LivesDisp;
`endif

  lives_manager #(
    .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .RESPAWN_CYCLES(RC), .BLINK_CYCLES(BC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .NewGame(NewGame), .BallLost(BallLost),
    .BonusLife(BonusLife), .Lives(Lives), .Respawn(Respawn), .GameOver(GameOver)
`ifdef LIVES_BLINK_EN
    , .LivesDisp(LivesDisp)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit    rst_n, ng, bl, bo;
    int    lives;
    bit    resp, over;
    int    disp;
    string name;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game status in plain terms.
  int m_lives = 0, m_resp_left = 0, m_elapsed = 0;
  bit m_active = 0, m_over = 0;

  function automatic int sat_inc(input int v);
    return (v + 1 > MAXL) ? MAXL : v + 1;
  endfunction

  function automatic int model_disp();
    if (m_resp_left > 0) return (((m_elapsed / BC) % 2) == 0) ? 0 : m_lives;
    return m_lives;
  endfunction

  task automatic model_update(input bit rst_n, ng, bl, bo);
    if (!rst_n) begin
      m_lives = 0; m_resp_left = 0; m_elapsed = 0; m_active = 0; m_over = 0;
    end else if (ng) begin
      m_lives = INIT; m_resp_left = 0; m_elapsed = 0; m_active = 1; m_over = 0;
    end else if (m_active) begin
      if (m_resp_left > 0) begin
        m_resp_left--;
        m_elapsed++;
        if (bo) m_lives = sat_inc(m_lives);
      end else if (bl) begin
        if (bo || m_lives > 1) begin
          if (!bo) m_lives--;
          m_resp_left = RC;
          m_elapsed = 0;
        end else begin
          m_lives = 0; m_over = 1; m_active = 0;
        end
      end else if (bo) begin
        m_lives = sat_inc(m_lives);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit rst_n, ng, bl, bo);
    Reset_n = rst_n; NewGame = ng; BallLost = bl; BonusLife = bo;
    @(posedge Clk);
    #1;
    model_update(rst_n, ng, bl, bo);
  endtask

  function automatic void add(input bit rst_n, ng, bl, bo, input int l, input bit r, g,
                              input int d, input string name);
    vec_t v;
    v.rst_n = rst_n; v.ng = ng; v.bl = bl; v.bo = bo;
    v.lives = l; v.resp = r; v.over = g; v.disp = d; v.name = name;
    vecs.push_back(v);
  endfunction

  // Four idle cycles of a respawn window following a loss, landing on `l` lives.
  function automatic void add_resp_tail(input int l, input string name);
    add(1,0,0,0, l,1,0, 0, name);
    add(1,0,0,0, l,1,0, l, name);
    add(1,0,0,0, l,1,0, l, name);
    add(1,0,0,0, l,0,0, l, {name, "_end"});
  endfunction

  initial begin
    //  rst ng bl bo  lives resp over disp
    add(0,0,0,0, 0,0,0, 0, "reset");
    add(0,0,0,0, 0,0,0, 0, "reset_hold");
    add(1,0,1,0, 0,0,0, 0, "idle_ignore_bl");
    add(1,0,0,1, 0,0,0, 0, "idle_ignore_bo");
    add(1,1,0,0, 3,0,0, 3, "newgame");
    add(1,0,0,0, 3,0,0, 3, "play_hold");
    add(1,0,1,0, 2,1,0, 0, "lost_3to2");
    add(1,0,1,0, 2,1,0, 0, "bl_in_respawn");
    add(1,0,0,0, 2,1,0, 2, "resp_c3");
    add(1,0,0,0, 2,1,0, 2, "resp_c4");
    add(1,0,0,0, 2,0,0, 2, "resp_done");
    add(1,0,1,0, 1,1,0, 0, "lost_2to1");
    add_resp_tail(1, "resp_1");
    add(1,0,1,0, 0,0,1, 0, "game_over");
    add(1,0,1,0, 0,0,1, 0, "over_ignore_bl");
    add(1,0,0,1, 0,0,1, 0, "over_ignore_bo");
    add(1,1,0,0, 3,0,0, 3, "newgame_from_over");
    for (int i = 0; i < 7; i++)
      add(1,0,0,1, (4 + i > 9) ? 9 : 4 + i, 0,0, (4 + i > 9) ? 9 : 4 + i, "bonus_sat");
    add(1,0,0,1, 9,0,0, 9, "bonus_at_max");
    add(1,1,0,0, 3,0,0, 3, "newgame2");
    add(1,0,1,0, 2,1,0, 0, "lost_again");
    add(1,0,0,0, 2,1,0, 0, "resp_b1");
    add(1,0,0,1, 3,1,0, 3, "bonus_in_respawn");
    add(1,0,0,0, 3,1,0, 3, "resp_b3");
    add(1,0,0,0, 3,0,0, 3, "resp_b_end");
    add(1,0,1,0, 2,1,0, 0, "lost_before_reset");
    add(1,0,0,0, 2,1,0, 0, "resp_r1");
    add(0,0,0,0, 0,0,0, 0, "reset_mid_respawn");
    add(1,1,0,0, 3,0,0, 3, "newgame3");
    add(1,0,1,0, 2,1,0, 0, "lost_before_ng");
    add(1,1,0,0, 3,0,0, 3, "newgame_mid_respawn");
    add(1,0,0,0, 3,0,0, 3, "no_resume");
    add(1,0,1,0, 2,1,0, 0, "lost_3to2_b");
    add_resp_tail(2, "resp_2");
    add(1,0,1,0, 1,1,0, 0, "lost_2to1_b");
    add_resp_tail(1, "resp_1b");
    add(1,0,1,1, 1,1,0, 0, "combo_at_one");
    add_resp_tail(1, "resp_combo");
    add(1,1,1,1, 3,0,0, 3, "newgame_priority");
    add(1,0,1,0, 2,1,0, 0, "held_bl_1");
    add(1,0,1,0, 2,1,0, 0, "held_bl_2");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].ng, vecs[i].bl, vecs[i].bo);
      check($sformatf("v%0d_%s lives", i, vecs[i].name), int'(Lives), vecs[i].lives);
      check($sformatf("v%0d_%s respawn", i, vecs[i].name), int'(Respawn), int'(vecs[i].resp));
      check($sformatf("v%0d_%s gameover", i, vecs[i].name), int'(GameOver), int'(vecs[i].over));
`ifdef LIVES_BLINK_EN
      check($sformatf("v%0d_%s disp", i, vecs[i].name), int'(LivesDisp), vecs[i].disp);
`endif
    end

    for (int c = 0; c < 3000; c++) begin
      bit rn, ng, bl, bo;
      rn = ($urandom_range(0, 199) != 0);
      ng = ($urandom_range(0, 39) == 0);
      bl = ($urandom_range(0, 5) == 0);
      bo = ($urandom_range(0, 7) == 0);
      step(rn, ng, bl, bo);
      check($sformatf("rnd%0d lives", c), int'(Lives), m_lives);
      check($sformatf("rnd%0d respawn", c), int'(Respawn), int'(m_resp_left > 0));
      check($sformatf("rnd%0d gameover", c), int'(GameOver), int'(m_over));
`ifdef LIVES_BLINK_EN
      check($sformatf("rnd%0d disp", c), int'(LivesDisp), model_disp());
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
